// File: rtl/sev_seg_pkg.sv
// Shared seven-segment constants: the hex glyph table, the blank pattern
// and the scan-decoder FSM state type.
package sev_seg_pkg;

  // Segment order is gfedcba, with a in bit 0. Entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_LOCKED = 2'd3
  } scan_state_e;

endpackage

// File: rtl/sev_seg_inv.sv
// Inverse seven-segment lookup: pattern -> {legal, blank, nibble}.
module sev_seg_inv
  import sev_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  // Search the glyph table; nibble is only meaningful when legal is set.
  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/sev_seg_scan_decoder.sv
// Readback monitor for a multiplexed seven-segment bus: waits for a stable
// segment/select pair, decodes it into the selected digit slot, and reports
// illegal glyphs, bad selects and completed scan frames.
module sev_seg_scan_decoder
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    sel_err
);

  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CYCLES - 1);

  logic [6:0]              s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0]   s_sel_q, s_sel_d;
  logic [7:0]              cnt_q, cnt_d;
  scan_state_e             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    frame_done_q, frame_done_d;
  logic                    pattern_err_q, pattern_err_d;
  logic                    sel_err_q, sel_err_d;

  logic       same;
  logic       sel_none;
  logic       sel_multi;
  logic       inv_legal;
  logic       inv_blank;
  logic [3:0] inv_nibble;

  sev_seg_inv u_inv (
    .seg    (s_seg_q),
    .legal  (inv_legal),
    .blank  (inv_blank),
    .nibble (inv_nibble)
  );

  // The sample being captured this edge matches the one already held, so
  // the counter always describes the run length of the registered sample.
  assign same      = (segments == s_seg_q) && (dig_sel == s_sel_q);
  assign sel_none  = (s_sel_q == '0);
  assign sel_multi = ((s_sel_q & (s_sel_q - NUM_DIGITS'(1))) != '0);

  // Stage-0 sampling and saturating stability counter.
  always_comb begin
    s_seg_d = segments;
    s_sel_d = dig_sel;
    cnt_d   = 8'd0;
    if (same) begin
      cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 8'd1 : cnt_q;
    end
  end

  // Next-state logic: count a stable run, commit once, then hold until change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (same) begin
          state_d = (cnt_d >= CNT_COMMIT) ? ST_COMMIT : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!same) begin
          state_d = ST_WAIT;
        end else if (cnt_d >= CNT_COMMIT) begin
          state_d = ST_COMMIT;
        end
      end
      // A change arriving on the commit edge must not be swallowed by LOCKED.
      ST_COMMIT: state_d = same ? ST_LOCKED : ST_WAIT;
      ST_LOCKED: begin
        if (!same) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Commit actions: slot update, error pulses and frame tracking.
  always_comb begin
    value_d       = value_q;
    valid_d       = valid_q;
    seen_d        = seen_q;
    seen_next     = seen_q | s_sel_q;
    frame_done_d  = 1'b0;
    pattern_err_d = 1'b0;
    sel_err_d     = 1'b0;
    if (state_q == ST_COMMIT) begin
      if (sel_multi) begin
        sel_err_d = 1'b1;
      end else if (!sel_none) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (s_sel_q[i]) begin
            if (inv_legal) begin
              value_d[4*i +: 4] = inv_nibble;
              valid_d[i]        = 1'b1;
            end else begin
              valid_d[i]        = 1'b0;
            end
          end
        end
        pattern_err_d = !inv_legal && !inv_blank;
        // The completing commit belongs to the finished frame only.
        if (&seen_next) begin
          frame_done_d = 1'b1;
          seen_d       = '0;
        end else begin
          seen_d       = seen_next;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q       <= '0;
      s_sel_q       <= '0;
      cnt_q         <= '0;
      state_q       <= ST_WAIT;
      value_q       <= '0;
      valid_q       <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      s_seg_q       <= s_seg_d;
      s_sel_q       <= s_sel_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      value_q       <= value_d;
      valid_q       <= valid_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      pattern_err_q <= pattern_err_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign pattern_err = pattern_err_q;
  assign sel_err     = sel_err_q;

endmodule

// File: doc/sev_seg_scan_decoder.md
# sev_seg_scan_decoder

Receiving end of the seven-segment path: samples a time-multiplexed segment bus (gfedcba, active-high, a = bit 0) together with one-hot digit-select lines, waits for each pattern to be stable, and decodes it back to a hex nibble per digit position. It sits beside `sev_seg`-driven display logic as an on-chip readback and self-check monitor. It assembles a multi-digit value, flags illegal patterns and bad selects, and reports each complete scan frame.

## Interface
- `NUM_DIGITS`, 4: digit positions, 1..8.
- `STABLE_CYCLES`, 8: consecutive identical samples required before commit, 2..255.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `segments`  in  7: observed segment pattern gfedcba, 1 = lit.
- `dig_sel`  in  NUM_DIGITS: digit enables, 1 = active, one-hot expected.
- `value`  out  4*NUM_DIGITS: decoded nibbles; digit i at `value[4i+3:4i]`.
- `digit_valid`  out  NUM_DIGITS: 1 = slot i holds a legally decoded nibble.
- `frame_done`  out  1: one-cycle pulse when every digit has committed since the last pulse.
- `pattern_err`  out  1: one-cycle pulse on commit of an illegal, non-blank pattern.
- `sel_err`  out  1: one-cycle pulse when a stable `dig_sel` has more than one bit set.

## Operation
- Stage 0: `segments`/`dig_sel` registered every cycle into `s_seg`/`s_sel`. All decisions use registered samples.
- Stability counter `cnt` (8 bit):
  - Cleared when `s_seg`/`s_sel` differs from the previous sample.
  - Otherwise incremented, saturating at `STABLE_CYCLES`.
- FSM:
  - WAIT → COUNT when the sample repeats.
  - COUNT → WAIT on any change.
  - COUNT → COMMIT when `cnt` reaches `STABLE_CYCLES-1`, meaning STABLE_CYCLES identical samples.
  - COMMIT lasts one cycle, then goes to LOCKED.
  - LOCKED → WAIT on any change. No second commit for the same held pattern.
- COMMIT actions, with index i = position of the single set bit of `s_sel`:
  - Legal hex pattern: write the nibble to slot i, set `digit_valid[i]`, set `seen[i]`.
  - Blank (7'h00): clear `digit_valid[i]`, keep the old nibble, set `seen[i]`. No error.
  - Any other pattern: clear `digit_valid[i]`, keep the old nibble, set `seen[i]`, pulse `pattern_err`.
- Bad select at COMMIT:
  - `s_sel` == 0: no write, no error, go to LOCKED.
  - More than one bit set: no write, pulse `sel_err`, go to LOCKED.
- Legal patterns:
  - 0–3: 3F 06 5B 4F
  - 4–7: 66 6D 7D 07
  - 8–B: 7F 6F 77 7C
  - C–F: 39 5E 79 71
- Frame tracking:
  - When `seen` becomes all-ones, pulse `frame_done` on the same edge that writes the last slot.
  - `seen` clears on that edge; the commit that completes the frame counts only toward the finished frame.
  - Re-committing an already-seen digit within a frame overwrites the slot and does not advance the frame.
- Simultaneous `pattern_err` and `frame_done` on one edge is legal.

## Timing
- Reset values:
  - `value` = 0, `digit_valid` = 0.
  - `frame_done`/`pattern_err`/`sel_err` = 0.
  - `cnt` = 0, `seen` = 0, state WAIT.
  - Sample registers = 0.
- Latency: inputs changed before edge N and held constant → outputs updated by edge N+STABLE_CYCLES.
- Any input change resets the count. A glitch shorter than STABLE_CYCLES never commits.
- Reset mid-count or mid-frame discards all progress; the next commit requires a full STABLE_CYCLES from the first post-reset sample.
- Pulses are high exactly one cycle. No handshake or back-pressure.

## Structure
- Package `sev_seg_pkg` holds:
  - the 16-entry pattern constant table (shared with `sev_seg`);
  - the blank constant 7'h00;
  - the FSM state enum.
- Sub-module `sev_seg_inv`: combinational pattern → {legal, blank, nibble[3:0]} lookup, instanced once.
- Top level holds the sample registers, counter, FSM, slot registers and `seen` mask.

## Test plan
All scenarios use `STABLE_CYCLES` = 4, `NUM_DIGITS` = 4.
- Hold `dig_sel`=0001, `segments`=7'h5B for 6 cycles → `value[3:0]`=2 and `digit_valid[0]`=1 four edges after first sample; exactly one commit.
- `segments`=7'h06 for 2 cycles, then 7'h4F held → no write of 1; `value[3:0]`=3 four edges after the change.
- `dig_sel`=0010, `segments`=7'h7E held → one `pattern_err` pulse, `digit_valid[1]`=0, `value[7:4]` unchanged.
- `dig_sel`=0011 held → one `sel_err` pulse, `value`/`digit_valid` unchanged.
- Scan digits 0..3 with patterns 6D, 66, 4F, 5B (5,4,3,2), each held 5 cycles → `value`=16'h2345, `digit_valid`=1111, single `frame_done` on digit 3's commit edge.
- Assert `rst` after 3 stable cycles of digit 0 → all outputs 0; after release, commit requires 4 fresh stable samples.
